// File: rtl/hpu_get_pkg.sv
// rtl/hpu_get_pkg.sv - shared state type and host-mode decode for the get dispatcher
package hpu_get_pkg;

    typedef enum logic [2:0] {IDLE, GEN, RUN, COM, ERR} get_state_t;

    // ERR persists while any mode line stays high; only all-low returns to IDLE.
    function automatic get_state_t mode_decode(
        input logic       gen,
        input logic       run,
        input logic       com,
        input get_state_t cur
    );
        logic [1:0] n_high;
        n_high = {1'b0, gen} + {1'b0, run} + {1'b0, com};
        if (n_high == 2'd0)                  return IDLE;
        else if (cur == ERR || n_high >= 2'd2) return ERR;
        else if (gen)                        return GEN;
        else if (run)                        return RUN;
        else                                 return COM;
    endfunction

endpackage

// File: rtl/get_fifo.sv
// rtl/get_fifo.sv - synchronous run-word FIFO with wrap-bit pointers and synchronous flush
module get_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;
    assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/get_dispatch.sv
// rtl/get_dispatch.sv - host-mode gated receive path: run words buffered and issued as exec pulses, com words latched
module get_dispatch
    import hpu_get_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int EXEC_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_gen,
    input  logic              i_run,
    input  logic              i_com,
    input  logic              i_get_valid,
    input  logic [DATA_W-1:0] i_get_data,
    output logic              o_get_ready,
    input  logic              i_exec_ready,
    output logic              o_exec,
    output logic [DATA_W-1:0] o_exec_data,
    output logic              o_get_c,
    output logic [DATA_W-1:0] o_com_data,
    output logic [CNT_W-1:0]  o_rcv_cnt,
    output logic              o_mode_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    get_state_t        r_state;
    get_state_t        w_next;
    logic [CNT_W-1:0]  r_rcv_cnt;
    logic [DATA_W-1:0] r_com_data;
    logic [EXEC_LAT-1:0] r_pipe_v;
    logic [DATA_W-1:0] r_pipe_d [EXEC_LAT];

    logic              w_in_run;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;

    assign w_next      = mode_decode(i_gen, i_run, i_com, r_state);
    assign w_in_run    = (r_state == RUN);
    // Ready depends only on registered state and full, never on i_exec_ready.
    assign o_get_ready = (r_state == COM) | (w_in_run & ~w_full);
    assign w_accept    = i_get_valid & o_get_ready;
    assign w_push      = w_accept & w_in_run;
    assign o_get_c     = w_accept & (r_state == COM);
    assign w_pop       = w_in_run & ~w_empty & i_exec_ready;
    assign w_flush     = (w_next != RUN);

    assign o_exec      = r_pipe_v[EXEC_LAT-1];
    assign o_exec_data = r_pipe_d[EXEC_LAT-1];
    assign o_com_data  = r_com_data;
    assign o_rcv_cnt   = r_rcv_cnt;
    assign o_mode_err  = (r_state == ERR);

    get_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_push_data (i_get_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_rcv_cnt  <= '0;
            r_com_data <= '0;
        end else begin
            r_state <= w_next;
            if (!w_in_run && w_next == RUN)
                r_rcv_cnt <= '0;
            else if (w_push && r_rcv_cnt != CNT_MAX)
                r_rcv_cnt <= r_rcv_cnt + CNT_W'(1);
            if (o_get_c)
                r_com_data <= i_get_data;
        end
    end

    // Popped words travel EXEC_LAT stages; leaving RUN drops anything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe_v <= '0;
            for (int i = 0; i < EXEC_LAT; i++) r_pipe_d[i] <= '0;
        end else if (w_flush) begin
            r_pipe_v <= '0;
            for (int i = 0; i < EXEC_LAT; i++) r_pipe_d[i] <= '0;
        end else begin
            r_pipe_v[0] <= w_pop;
            r_pipe_d[0] <= w_fifo_data;
            for (int i = 1; i < EXEC_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_d[i] <= r_pipe_d[i-1];
            end
        end
    end

endmodule

// File: tb/tb_get_dispatch.sv
// tb/tb_get_dispatch.sv - scoreboard bench for get_dispatch at EXEC_LAT 1 and 3
module tb_get_dispatch;
    logic        clk = 1'b0;
    logic        rst_n, gen, run, com, get_valid, exec_ready;
    logic [31:0] get_data;

    logic        get_ready1, exec1, get_c1, mode_err1;
    logic [31:0] exec_data1, com_data1;
    logic [15:0] rcv_cnt1;
    logic        get_ready3, exec3, get_c3, mode_err3;
    logic [31:0] exec_data3, com_data3;
    logic [15:0] rcv_cnt3;

    int chk = 0, err = 0, cyc = 0;
    int n_exec1 = 0, n_exec3 = 0, t_exec1 = 0, t_exec3 = 0, t_push = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    always #5 clk = ~clk;

    get_dispatch #(.DATA_W(32), .DEPTH(4), .EXEC_LAT(1), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_gen(gen), .i_run(run), .i_com(com),
        .i_get_valid(get_valid), .i_get_data(get_data), .o_get_ready(get_ready1),
        .i_exec_ready(exec_ready), .o_exec(exec1), .o_exec_data(exec_data1),
        .o_get_c(get_c1), .o_com_data(com_data1), .o_rcv_cnt(rcv_cnt1), .o_mode_err(mode_err1));

    get_dispatch #(.DATA_W(32), .DEPTH(4), .EXEC_LAT(3), .CNT_W(16)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_gen(gen), .i_run(run), .i_com(com),
        .i_get_valid(get_valid), .i_get_data(get_data), .o_get_ready(get_ready3),
        .i_exec_ready(exec_ready), .o_exec(exec3), .o_exec_data(exec_data3),
        .o_get_c(get_c3), .o_com_data(com_data3), .o_rcv_cnt(rcv_cnt3), .o_mode_err(mode_err3));

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (exec1) begin
                n_exec1++;
                t_exec1 = cyc;
                chk++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL exec_unexpected got=%h expected=no_exec", exec_data1);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (exec_data1 !== exp_w) begin
                        err++;
                        $display("FAIL exec_data got=%h expected=%h", exec_data1, exp_w);
                    end
                end
            end
            if (exec3) begin
                n_exec3++;
                t_exec3 = cyc;
            end
            if (get_valid && get_ready1 && !get_c1) begin
                exp_q.push_back(get_data);
                t_push = cyc;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        int b;
        get_valid = 1'b1;
        get_data  = d;
        for (b = 0; b < 50 && !get_ready1; b++) cycle();
        if (!get_ready1) begin
            chk++; err++;
            $display("FAIL ready_timeout got=0 expected=1 word=%h", d);
        end
        cycle();
        get_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gen = 0; run = 0; com = 0; get_valid = 0; exec_ready = 0; get_data = '0;
        repeat (2) cycle();
        chk++; if (get_ready1 !== 1'b0) begin err++; $display("FAIL rst_ready got=%b expected=0", get_ready1); end
        chk++; if (exec1 !== 1'b0 || exec_data1 !== 32'h0) begin err++; $display("FAIL rst_exec got=%b/%h expected=0/0", exec1, exec_data1); end
        chk++; if (com_data1 !== 32'h0 || rcv_cnt1 !== 16'h0) begin err++; $display("FAIL rst_regs got=%h/%h expected=0/0", com_data1, rcv_cnt1); end
        chk++; if (mode_err1 !== 1'b0 || get_c1 !== 1'b0) begin err++; $display("FAIL rst_flags got=%b/%b expected=0/0", mode_err1, get_c1); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_back_to_back();
        int s;
        run = 1; exec_ready = 1;
        cycle();
        chk++; if (get_ready1 !== 1'b1) begin err++; $display("FAIL b2b_ready got=%b expected=1", get_ready1); end
        s = n_exec1;
        send_word(32'h1111_0001);
        send_word(32'h1111_0002);
        send_word(32'h1111_0003);
        repeat (6) cycle();
        chk++; if (n_exec1 - s != 3) begin err++; $display("FAIL b2b_count got=%0d expected=3", n_exec1 - s); end
        chk++; if (rcv_cnt1 !== 16'd3) begin err++; $display("FAIL b2b_rcv_cnt got=%0d expected=3", rcv_cnt1); end
        chk++; if (t_exec1 - t_push != 2) begin err++; $display("FAIL b2b_lat1 got=%0d expected=2", t_exec1 - t_push); end
        chk++; if (t_exec3 - t_push != 4) begin err++; $display("FAIL b2b_lat3 got=%0d expected=4", t_exec3 - t_push); end
    endtask

    task automatic test_backpressure();
        int s;
        exec_ready = 0;
        s = n_exec1;
        for (int k = 0; k < 4; k++) send_word(32'hB000_0000 + 32'(k));
        get_valid = 1; get_data = 32'hB000_0004;
        chk++; if (get_ready1 !== 1'b0) begin err++; $display("FAIL bp_full_ready got=%b expected=0", get_ready1); end
        repeat (2) cycle();
        chk++; if (get_ready1 !== 1'b0 || n_exec1 != s) begin err++; $display("FAIL bp_hold got=%b/%0d expected=0/%0d", get_ready1, n_exec1, s); end
        exec_ready = 1;
        #1;
        chk++; if (get_ready1 !== 1'b0) begin err++; $display("FAIL bp_no_comb_path got=%b expected=0", get_ready1); end
        send_word(32'hB000_0004);
        send_word(32'hB000_0005);
        repeat (8) cycle();
        chk++; if (n_exec1 - s != 6 || exp_q.size() != 0) begin err++; $display("FAIL bp_drain got=%0d/%0d expected=6/0", n_exec1 - s, exp_q.size()); end
        chk++; if (rcv_cnt1 !== 16'd9) begin err++; $display("FAIL bp_rcv_cnt got=%0d expected=9", rcv_cnt1); end
    endtask

    task automatic test_flush();
        int s, s3;
        exec_ready = 0;
        send_word(32'hF000_0001);
        send_word(32'hF000_0002);
        run = 0; exec_ready = 1;
        cycle();
        chk++; if (get_ready1 !== 1'b0) begin err++; $display("FAIL fl_ready got=%b expected=0", get_ready1); end
        exp_q.delete();
        s = n_exec1; s3 = n_exec3;
        repeat (6) cycle();
        chk++; if (n_exec1 != s || n_exec3 != s3) begin err++; $display("FAIL fl_no_exec got=%0d/%0d expected=%0d/%0d", n_exec1, n_exec3, s, s3); end
        chk++; if (rcv_cnt1 !== 16'd11) begin err++; $display("FAIL fl_cnt_hold got=%0d expected=11", rcv_cnt1); end
        run = 1;
        cycle();
        chk++; if (rcv_cnt1 !== 16'd0 || get_ready1 !== 1'b1) begin err++; $display("FAIL fl_reentry got=%0d/%b expected=0/1", rcv_cnt1, get_ready1); end
        repeat (3) cycle();
        chk++; if (n_exec1 != s) begin err++; $display("FAIL fl_fifo_empty got=%0d expected=%0d", n_exec1, s); end
        send_word(32'hC0FF_EE01);
        repeat (3) cycle();
        chk++; if (n_exec1 != s + 1 || rcv_cnt1 !== 16'd1) begin err++; $display("FAIL fl_after got=%0d/%0d expected=%0d/1", n_exec1, rcv_cnt1, s + 1); end
        run = 0;
        cycle();
    endtask

    task automatic test_com();
        int s;
        com = 1;
        cycle();
        chk++; if (get_ready1 !== 1'b1 || get_c1 !== 1'b0) begin err++; $display("FAIL com_ready got=%b/%b expected=1/0", get_ready1, get_c1); end
        s = n_exec1;
        get_valid = 1; get_data = 32'hA5A5_0001;
        #1;
        chk++; if (get_c1 !== 1'b1) begin err++; $display("FAIL com_get_c got=%b expected=1", get_c1); end
        cycle();
        get_valid = 0;
        #1;
        chk++; if (com_data1 !== 32'hA5A5_0001 || get_c1 !== 1'b0) begin err++; $display("FAIL com_data got=%h/%b expected=a5a50001/0", com_data1, get_c1); end
        com = 0;
        repeat (2) cycle();
        chk++; if (n_exec1 != s) begin err++; $display("FAIL com_no_exec got=%0d expected=%0d", n_exec1, s); end
    endtask

    task automatic test_err();
        run = 1; com = 1; get_valid = 1; get_data = 32'hDEAD_BEEF;
        cycle();
        chk++; if (mode_err1 !== 1'b1 || get_ready1 !== 1'b0 || get_c1 !== 1'b0) begin err++; $display("FAIL err_enter got=%b/%b/%b expected=1/0/0", mode_err1, get_ready1, get_c1); end
        com = 0;
        cycle();
        chk++; if (mode_err1 !== 1'b1 || get_ready1 !== 1'b0) begin err++; $display("FAIL err_sticky got=%b/%b expected=1/0", mode_err1, get_ready1); end
        run = 0;
        cycle();
        chk++; if (mode_err1 !== 1'b0 || get_ready1 !== 1'b0) begin err++; $display("FAIL err_exit got=%b/%b expected=0/0", mode_err1, get_ready1); end
        chk++; if (com_data1 !== 32'hA5A5_0001) begin err++; $display("FAIL err_com_hold got=%h expected=a5a50001", com_data1); end
        get_valid = 0;
    endtask

    task automatic test_reset_mid();
        int s3;
        run = 1; exec_ready = 1;
        cycle();
        send_word(32'hE000_0001);
        get_valid = 1;
        send_word(32'hE000_0002);
        get_valid = 1;
        send_word(32'hE000_0003);
        chk++; if (get_ready3 !== 1'b1 || exec1 !== 1'b1) begin err++; $display("FAIL rm_pre got=%b/%b expected=1/1", get_ready3, exec1); end
        #2;
        rst_n = 0;
        #1;
        exp_q.delete();
        chk++; if (get_ready3 !== 1'b0 || exec3 !== 1'b0 || exec_data3 !== 32'h0) begin err++; $display("FAIL rm_dut3_exec got=%b/%b/%h expected=0/0/0", get_ready3, exec3, exec_data3); end
        chk++; if (rcv_cnt3 !== 16'h0 || com_data3 !== 32'h0 || mode_err3 !== 1'b0 || get_c3 !== 1'b0) begin err++; $display("FAIL rm_dut3_regs got=%h/%h/%b/%b expected=0/0/0/0", rcv_cnt3, com_data3, mode_err3, get_c3); end
        chk++; if (exec1 !== 1'b0 || rcv_cnt1 !== 16'h0) begin err++; $display("FAIL rm_dut1 got=%b/%h expected=0/0", exec1, rcv_cnt1); end
        run = 0; get_valid = 0;
        s3 = n_exec3;
        repeat (2) cycle();
        rst_n = 1;
        repeat (6) cycle();
        chk++; if (n_exec3 != s3) begin err++; $display("FAIL rm_suppressed got=%0d expected=%0d", n_exec3, s3); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_com();
        test_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
